// File: rtl/force_output_ring_node_mc.sv
// Multi-lane force output ring node: buffers PE force packets per lane, merges them onto the force
// ring behind ring traffic, and ejects packets addressed to this node's cell into the force cache.
module force_output_ring_node_mc #(
    parameter int unsigned NUM_CH               = 2,
    parameter int unsigned FIFO_DEPTH           = 16,
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned PARTICLE_ID_WIDTH    = 7,
    parameter int unsigned GLOBAL_CELL_ID_WIDTH = 3,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_X = '0,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Y = '0,
    parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Z = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_CH*3*DATA_WIDTH-1:0]           i_pe_force,
    input  logic [NUM_CH*PARTICLE_ID_WIDTH-1:0]      i_pe_parid,
    input  logic [NUM_CH*3*GLOBAL_CELL_ID_WIDTH-1:0] i_pe_gcid,
    input  logic [NUM_CH-1:0]                        i_pe_valid,
    output logic [NUM_CH-1:0]                        o_pe_ready,
    input  logic [3*DATA_WIDTH-1:0]                  i_source_nb_force,
    input  logic [PARTICLE_ID_WIDTH-1:0]             i_source_nb_parid,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]        i_source_nb_gcid,
    input  logic                                     i_source_nb_valid,
    output logic [3*DATA_WIDTH-1:0]                  o_dest_nb_force,
    output logic [PARTICLE_ID_WIDTH-1:0]             o_dest_nb_parid,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]        o_dest_nb_gcid,
    output logic                                     o_dest_nb_valid,
    output logic [3*DATA_WIDTH-1:0]                  o_nb_force_to_force_cache,
    output logic [PARTICLE_ID_WIDTH-1:0]             o_nb_parid_to_force_cache,
    output logic                                     o_nb_force_to_force_cache_valid,
    output logic                                     o_buffer_empty,
    output logic [15:0]                              o_overflow_cnt
);
    localparam int unsigned FW   = 3 * DATA_WIDTH;
    localparam int unsigned PW   = PARTICLE_ID_WIDTH;
    localparam int unsigned GW   = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int unsigned KW   = FW + PW + GW;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTRW = AW + 1;
    localparam int unsigned CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [GW-1:0] MY_GCID = {GCELL_X, GCELL_Y, GCELL_Z};

    logic [KW-1:0]     mem_q      [NUM_CH][FIFO_DEPTH];
    logic [PTRW-1:0]   wr_ptr_q   [NUM_CH];
    logic [PTRW-1:0]   wr_ptr_d   [NUM_CH];
    logic [PTRW-1:0]   rd_ptr_q   [NUM_CH];
    logic [PTRW-1:0]   rd_ptr_d   [NUM_CH];
    logic [KW-1:0]     in_pkt_c   [NUM_CH];
    logic [KW-1:0]     head_pkt_c [NUM_CH];
    logic [NUM_CH-1:0] full_q, full_d;
    logic [NUM_CH-1:0] push_c, pop_c, head_vld_c, head_match_c;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [FW-1:0] dest_force_q, dest_force_d;
    logic [PW-1:0] dest_parid_q, dest_parid_d;
    logic [GW-1:0] dest_gcid_q, dest_gcid_d;
    logic          dest_valid_q, dest_valid_d;
    logic [FW-1:0] cache_force_q, cache_force_d;
    logic [PW-1:0] cache_parid_q, cache_parid_d;
    logic          cache_valid_q, cache_valid_d;
    logic          buffer_empty_q, buffer_empty_d;
    logic [15:0]   ovf_cnt_q, ovf_cnt_d;
    logic [16:0]   ovf_sum_c;
    logic          all_empty_c;

    // Lane packet is {force, parid, gcid}; gcid in the LSBs for cheap matching.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign in_pkt_c[k]     = {i_pe_force[k*FW +: FW], i_pe_parid[k*PW +: PW], i_pe_gcid[k*GW +: GW]};
        assign push_c[k]       = i_pe_valid[k] & ~full_q[k];
        assign head_vld_c[k]   = wr_ptr_q[k] != rd_ptr_q[k];
        assign head_pkt_c[k]   = mem_q[k][rd_ptr_q[k][AW-1:0]];
        assign head_match_c[k] = head_pkt_c[k][GW-1:0] == MY_GCID;
    end

    // Ring input claims its slot first; lane heads then fill free slots in round-robin order.
    always_comb begin
        logic cache_free;
        logic ring_free;
        int   lane;
        dest_force_d  = '0;
        dest_parid_d  = '0;
        dest_gcid_d   = '0;
        dest_valid_d  = 1'b0;
        cache_force_d = '0;
        cache_parid_d = '0;
        cache_valid_d = 1'b0;
        pop_c         = '0;
        rr_ptr_d      = rr_ptr_q;
        cache_free    = 1'b1;
        ring_free     = 1'b1;
        lane          = 0;
        if (i_source_nb_valid) begin
            if (i_source_nb_gcid == MY_GCID) begin
                cache_force_d = i_source_nb_force;
                cache_parid_d = i_source_nb_parid;
                cache_valid_d = 1'b1;
                cache_free    = 1'b0;
            end else begin
                dest_force_d = i_source_nb_force;
                dest_parid_d = i_source_nb_parid;
                dest_gcid_d  = i_source_nb_gcid;
                dest_valid_d = 1'b1;
                ring_free    = 1'b0;
            end
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            lane = int'(rr_ptr_q) + i;
            if (lane >= int'(NUM_CH)) lane = lane - int'(NUM_CH);
            if (head_vld_c[lane]) begin
                if (head_match_c[lane] && cache_free) begin
                    cache_force_d = head_pkt_c[lane][KW-1 -: FW];
                    cache_parid_d = head_pkt_c[lane][GW +: PW];
                    cache_valid_d = 1'b1;
                    cache_free    = 1'b0;
                    pop_c[lane]   = 1'b1;
                    rr_ptr_d      = (lane == int'(NUM_CH) - 1) ? '0 : CW'(lane + 1);
                end else if (!head_match_c[lane] && ring_free) begin
                    dest_force_d = head_pkt_c[lane][KW-1 -: FW];
                    dest_parid_d = head_pkt_c[lane][GW +: PW];
                    dest_gcid_d  = head_pkt_c[lane][GW-1:0];
                    dest_valid_d = 1'b1;
                    ring_free    = 1'b0;
                    pop_c[lane]  = 1'b1;
                    rr_ptr_d     = (lane == int'(NUM_CH) - 1) ? '0 : CW'(lane + 1);
                end
            end
        end
    end

    // FIFO pointers, registered full flags, overflow counting and the idle flag.
    always_comb begin
        int ovf_add;
        ovf_add     = 0;
        all_empty_c = 1'b1;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + PTRW'(push_c[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PTRW'(pop_c[k]);
            full_d[k]   = (wr_ptr_d[k] - rd_ptr_d[k]) == PTRW'(FIFO_DEPTH);
            if (wr_ptr_d[k] != rd_ptr_d[k]) all_empty_c = 1'b0;
            if (i_pe_valid[k] && full_q[k]) ovf_add = ovf_add + 1;
        end
        ovf_sum_c      = 17'(ovf_cnt_q) + 17'(ovf_add);
        ovf_cnt_d      = ovf_sum_c[16] ? 16'hFFFF : ovf_sum_c[15:0];
        buffer_empty_d = all_empty_c && !dest_valid_d && !cache_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            full_q         <= '0;
            rr_ptr_q       <= '0;
            dest_force_q   <= '0;
            dest_parid_q   <= '0;
            dest_gcid_q    <= '0;
            dest_valid_q   <= 1'b0;
            cache_force_q  <= '0;
            cache_parid_q  <= '0;
            cache_valid_q  <= 1'b0;
            buffer_empty_q <= 1'b1;
            ovf_cnt_q      <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
            full_q         <= full_d;
            rr_ptr_q       <= rr_ptr_d;
            dest_force_q   <= dest_force_d;
            dest_parid_q   <= dest_parid_d;
            dest_gcid_q    <= dest_gcid_d;
            dest_valid_q   <= dest_valid_d;
            cache_force_q  <= cache_force_d;
            cache_parid_q  <= cache_parid_d;
            cache_valid_q  <= cache_valid_d;
            buffer_empty_q <= buffer_empty_d;
            ovf_cnt_q      <= ovf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (push_c[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= in_pkt_c[k];
        end
    end

    assign o_pe_ready                      = ~full_q;
    assign o_dest_nb_force                 = dest_force_q;
    assign o_dest_nb_parid                 = dest_parid_q;
    assign o_dest_nb_gcid                  = dest_gcid_q;
    assign o_dest_nb_valid                 = dest_valid_q;
    assign o_nb_force_to_force_cache       = cache_force_q;
    assign o_nb_parid_to_force_cache       = cache_parid_q;
    assign o_nb_force_to_force_cache_valid = cache_valid_q;
    assign o_buffer_empty                  = buffer_empty_q;
    assign o_overflow_cnt                  = ovf_cnt_q;

endmodule

// File: doc/force_output_ring_node_mc.md
Name: force_output_ring_node_mc

Overview:
- Multi-channel, parametrised successor of the single-PE force output ring node.
- Accepts neighbour-force packets from NUM_CH PE lanes into per-lane FIFOs, with ready/valid backpressure per lane.
- Merges them onto the unidirectional force ring and ejects packets addressed to this node's global cell into the local force cache.
- Ring traffic always has priority and is never stalled.

Parameters:
- NUM_CH, 2: number of PE input lanes (1..8).
- FIFO_DEPTH, 16: entries per lane FIFO (power of two, ≥2).
- DATA_WIDTH, 32: width of one force component.
- PARTICLE_ID_WIDTH, 7: particle id width.
- GLOBAL_CELL_ID_WIDTH, 3: width of one gcid coordinate.
- GCELL_X / GCELL_Y / GCELL_Z, 0: this node's cell coordinates, each GLOBAL_CELL_ID_WIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_pe_force  in  NUM_CH*3*DATA_WIDTH  per-lane force {z,y,x}; lane k at slice k.
- i_pe_parid  in  NUM_CH*PARTICLE_ID_WIDTH  per-lane destination particle id.
- i_pe_gcid  in  NUM_CH*3*GLOBAL_CELL_ID_WIDTH  per-lane destination gcid {x,y,z}, x in the MSBs.
- i_pe_valid  in  NUM_CH  per-lane valid.
- o_pe_ready  out  NUM_CH  per-lane ready; deasserted when that lane's FIFO is full.
- i_source_nb_force / _parid / _gcid / _valid  in  3*DATA_WIDTH / PARTICLE_ID_WIDTH / 3*GLOBAL_CELL_ID_WIDTH / 1  packet from the previous ring node.
- o_dest_nb_force / _parid / _gcid / _valid  out  same widths  packet to the next ring node.
- o_nb_force_to_force_cache  out  3*DATA_WIDTH  ejected force.
- o_nb_parid_to_force_cache  out  PARTICLE_ID_WIDTH  ejected particle id.
- o_nb_force_to_force_cache_valid  out  1  ejected packet valid.
- o_buffer_empty  out  1  all lane FIFOs empty and no output valid.
- o_overflow_cnt  out  16  count of lane pushes attempted while the lane was not ready (saturating).

Behaviour:
- Reset: all outputs 0, except o_pe_ready = all ones and o_buffer_empty = 1. FIFOs are emptied, the round-robin pointer is set to 0, and o_overflow_cnt is cleared. Reset mid-operation discards all buffered packets immediately.
- Own-cell match: gcid == {GCELL_X, GCELL_Y, GCELL_Z}.
- Lane push: occurs when i_pe_valid[k] && o_pe_ready[k]. o_pe_ready[k] = !full[k]. Ready is a registered full flag, so a pop in the same cycle does not make a full lane ready.
- Per-cycle resources: CACHE slot and RING slot. Both outputs are registered, with 1-cycle latency from the ring input or FIFO head. Outputs hold 0 data and valid 0 when not granted.
- Ring input (valid) takes first claim:
  - match → CACHE;
  - no match → RING (forwarded unchanged).
- Remaining free slots go to lane FIFO heads:
  - scan lanes from rr_ptr upward, modulo NUM_CH;
  - a head needing CACHE (match) or RING (no match) is granted if that slot is free;
  - at most one pop per slot, so up to 2 pops per cycle from distinct lanes;
  - a non-granted head stays at the head (no reordering within a lane).
- rr_ptr update: moves to (last granted lane + 1) mod NUM_CH. It is unchanged if nothing was granted.
- FIFO: circular, with a log2(FIFO_DEPTH)+1-bit wrap pointer. Simultaneous push and pop on a non-full lane keeps the occupancy unchanged. Pointers wrap silently.
- o_overflow_cnt: increments when i_pe_valid[k] && !o_pe_ready[k]. It increments by the number of such lanes in the cycle and saturates at 0xFFFF.
- o_buffer_empty: registered; 1 when all FIFOs are empty and neither output valid will assert next cycle.
- No arithmetic on force data; payloads pass bit-exact.

Test Plan:
- Reset and idle: hold rst=0 for 5 cycles, then release → o_pe_ready=2'b11, o_buffer_empty=1, all valids 0, o_overflow_cnt=0.
- Own-cell ejection: node (0,0,0); lane0 pushes parid=1, force 0x1/0x1/0x1, gcid 0 → exactly one cycle of cache valid with parid 1 and force unchanged; o_dest_nb_valid stays 0.
- Ring contention: in the same cycle, ring input (parid 6, gcid 0) and lane0 head (parid 8, gcid 0) arrive → cache gets 6 that cycle and 8 the next; 0 packets lost.
- Pass-through plus merge: ring input gcid 9'b001000000 together with lane1 head gcid 9'b010000000 → ring packet forwarded first, lane1 packet forwarded next cycle; lane0 head with gcid 0 ejected in parallel.
- Fairness: both lanes stream 8 non-local packets back-to-back with no ring traffic → o_dest grants alternate lane0, lane1, lane0, …; all 16 packets out in 16 cycles.
- Full and overflow: drive lane0 valid for 20 cycles with a continuous matching ring stream → o_pe_ready[0] drops after 16 pushes, o_overflow_cnt=4. Then stop the ring → FIFO drains 16 packets in order, ready reasserts, and o_buffer_empty=1 at the end.
